sprite_rom_arbiter: RTL and testbench

//  Shares one palette sprite ROM between N_REQ pixel requesters, e.g. the two player renderers

---
 rtl/sprite_rom_arbiter_if.sv | 25 ++
 rtl/sprite_rom_arbiter.sv | 96 +++++++++
 tb/tb_sprite_rom_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM bus for the sprite ROM arbiter.
// The slave side is the arbiter; the master side is the render pipelines plus the ROM.
interface sprite_rom_arbiter_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 6
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr_i;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_rgb;

  modport slave (
    input  req, addr_i, rom_rgb,
    output gnt, rvalid, rdata, rom_addr
  );

  modport master (
    output req, addr_i, rom_rgb,
    input  gnt, rvalid, rdata, rom_addr
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-output sprite ROM between N_REQ requesters.
// Responses are tagged through a ROM_LAT-deep shift register of one-hot grant + out-of-range bit.
module sprite_rom_arbiter #(
  parameter int unsigned       N_REQ    = 2,
  parameter int unsigned       ADDR_W   = 11,
  parameter int unsigned       DATA_W   = 6,
  parameter int unsigned       ROM_LAT  = 1,
  parameter int unsigned       ADDR_MAX = 1199,
  parameter logic [DATA_W-1:0] KEY_RGB  = 6'b110011
) (
  input logic                  clk,
  input logic                  rst_n,
  sprite_rom_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [N_REQ-1:0]  tag_gnt_q [ROM_LAT];
  logic [N_REQ-1:0]  tag_gnt_d [ROM_LAT];
  logic              tag_oor_q [ROM_LAT];
  logic              tag_oor_d [ROM_LAT];

  logic [N_REQ-1:0]  gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  idx;
  logic              gnt_any;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_oor;

  // Search upward from rr_ptr, wrapping; first asserted request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    if (rst_n) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = PTR_W'((32'(rr_ptr_q) + k) % N_REQ);
        if (!gnt_any && bus.req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
          gnt_any  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_addr = bus.addr_i[gnt_idx*ADDR_W +: ADDR_W];
    gnt_oor  = gnt_any && (32'(gnt_addr) > ADDR_MAX);

    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    rom_addr_d   = gnt_any ? gnt_addr : rom_addr_q;
    tag_gnt_d[0] = gnt;
    tag_oor_d[0] = gnt_oor;
    for (int unsigned s = 1; s < ROM_LAT; s++) begin
      tag_gnt_d[s] = tag_gnt_q[s-1];
      tag_oor_d[s] = tag_oor_q[s-1];
    end
  end

  always_comb begin
    bus.gnt      = gnt;
    bus.rom_addr = rst_n ? rom_addr_d : '0;
    bus.rvalid   = tag_gnt_q[ROM_LAT-1];
    bus.rdata    = '0;
    if (|tag_gnt_q[ROM_LAT-1]) begin
      bus.rdata = tag_oor_q[ROM_LAT-1] ? KEY_RGB : bus.rom_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rom_addr_q <= '0;
      for (int unsigned s = 0; s < ROM_LAT; s++) begin
        tag_gnt_q[s] <= '0;
        tag_oor_q[s] <= 1'b0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rom_addr_q <= rom_addr_d;
      for (int unsigned s = 0; s < ROM_LAT; s++) begin
        tag_gnt_q[s] <= tag_gnt_d[s];
        tag_oor_q[s] <= tag_oor_d[s];
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: ROM_LAT=1 and ROM_LAT=3 instances share one stimulus.
module tb_sprite_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [10:0] addr0 = '0;
  logic [10:0] addr1 = '0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Expected tag history: index 0 is the grant accepted at the most recent edge.
  logic [1:0]  hg [3];
  logic [10:0] ha [3];
  logic [10:0] held = '0;

  always #5 clk = ~clk;

  sprite_rom_arbiter_if #(.N_REQ(2), .ADDR_W(11), .DATA_W(6)) if1 ();
  sprite_rom_arbiter_if #(.N_REQ(2), .ADDR_W(11), .DATA_W(6)) if3 ();

  assign if1.req    = req;
  assign if1.addr_i = {addr1, addr0};
  assign if3.req    = req;
  assign if3.addr_i = {addr1, addr0};

  sprite_rom_arbiter #(.ROM_LAT(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  sprite_rom_arbiter #(.ROM_LAT(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3.slave)
  );

  function automatic logic [5:0] romf(input logic [10:0] a);
    int v;
    v = int'(a) * 7 + 3;
    return v[5:0];
  endfunction

  function automatic logic [5:0] exp_rd(input logic [1:0] g, input logic [10:0] a);
    if (g == 2'b00) return 6'd0;
    if (a > 11'd1199) return 6'b110011;
    return romf(a);
  endfunction

  // Registered ROM models with latency 1 and 3.
  logic [5:0] rom1_q;
  logic [5:0] rom3_q [3];
  always_ff @(posedge clk) begin
    rom1_q    <= romf(if1.rom_addr);
    rom3_q[0] <= romf(if3.rom_addr);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign if1.rom_rgb = rom1_q;
  assign if3.rom_rgb = rom3_q[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock: drive at negedge, check gnt/rom_addr, then check responses after the edge.
  task automatic tick(input logic rst, input logic [1:0] rq, input logic [10:0] a0,
                      input logic [10:0] a1, input logic [1:0] eg);
    logic [10:0] sel;
    logic [10:0] exp_addr;
    @(negedge clk);
    rst_n = rst;
    req   = rq;
    addr0 = a0;
    addr1 = a1;
    #1;
    sel      = (eg == 2'b01) ? a0 : (eg == 2'b10) ? a1 : 11'd0;
    exp_addr = !rst ? 11'd0 : (eg != 2'b00) ? sel : held;
    check("gnt_lat1", 32'(if1.gnt), 32'(eg));
    check("gnt_lat3", 32'(if3.gnt), 32'(eg));
    check("rom_addr_lat1", 32'(if1.rom_addr), 32'(exp_addr));
    check("rom_addr_lat3", 32'(if3.rom_addr), 32'(exp_addr));
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        hg[i] = 2'b00;
        ha[i] = '0;
      end
      held = '0;
    end else begin
      hg[2] = hg[1]; ha[2] = ha[1];
      hg[1] = hg[0]; ha[1] = ha[0];
      hg[0] = eg;    ha[0] = sel;
      if (eg != 2'b00) held = sel;
    end
    check("rvalid_lat1", 32'(if1.rvalid), 32'(hg[0]));
    check("rdata_lat1", 32'(if1.rdata), 32'(exp_rd(hg[0], ha[0])));
    check("rvalid_lat3", 32'(if3.rvalid), 32'(hg[2]));
    check("rdata_lat3", 32'(if3.rdata), 32'(exp_rd(hg[2], ha[2])));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 2'b00, 11'd0, 11'd0, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      hg[i] = 2'b00;
      ha[i] = '0;
    end

    // Reset held with both requesting: nothing granted or returned.
    for (int i = 0; i < 4; i++) tick(1'b0, 2'b11, 11'd5, 11'd6, 2'b00);

    // Lone requester 0 streaming addresses 0..9.
    for (int i = 0; i < 10; i++) tick(1'b1, 2'b01, 11'(i), 11'd0, 2'b01);
    idle(3);
    tick(1'b0, 2'b00, 11'd0, 11'd0, 2'b00);

    // Contention from reset: strict alternation starting at requester 0.
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 2'b11, 11'(100 + i), 11'(200 + i), (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle(3);

    // Grant to 1, idle, then both: pointer (now 0) survives idle cycles.
    tick(1'b1, 2'b10, 11'd0, 11'd50, 2'b10);
    idle(3);
    tick(1'b1, 2'b11, 11'd60, 11'd61, 2'b01);

    // Out-of-range reads return the transparency key; 1199 is still in range.
    tick(1'b1, 2'b10, 11'd0, 11'd1200, 2'b10);
    tick(1'b1, 2'b10, 11'd0, 11'd1199, 2'b10);
    tick(1'b1, 2'b10, 11'd0, 11'd2047, 2'b10);
    idle(3);

    // Reset mid-stream drops in-flight responses; first grant afterwards goes to 0.
    tick(1'b1, 2'b11, 11'd300, 11'd400, 2'b01);
    tick(1'b1, 2'b11, 11'd301, 11'd401, 2'b10);
    tick(1'b0, 2'b11, 11'd302, 11'd402, 2'b00);
    tick(1'b1, 2'b11, 11'd303, 11'd403, 2'b01);
    tick(1'b1, 2'b11, 11'd304, 11'd404, 2'b10);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
